symbol_freq_counter: RTL and testbench
======================================

// Module: symbol_freq_counter
// PURPOSE
//  Front stage of the Huffman accelerator, directly upstream of TableBuilder.
//  Consumes a raw byte stream, tallies occurrences per distinct symbol in a
//  NUM_SLOTS-entry table, then sorts entries by ascending frequency. Emits
//  (ascii, freq, queuePos) records one per handshake, ready to preload the
//  node Queue, so TableBuilder starts with queue position 0 = rarest symbol.
// PARAMETERS
//  NUM_SLOTS  6   distinct-symbol capacity; must match the Queue depth
//  FREQ_W     32  frequency counter width
//  SYM_W      8   symbol width
// PORTS
//  clk           in   1       rising-edge clock
//  ctrl_reset_n  in   1       asynchronous active-low reset
//  in_valid      in   1       in_byte valid
//  in_ready      out  1       block accepts a byte this cycle
//  in_byte       in   SYM_W   input symbol
//  in_last       in   1       qualifies the final byte of the message
//  out_valid     out  1       output record valid
//  out_ready     in   1       downstream accepts the record
//  out_ascii     out  SYM_W   symbol of the record
//  out_freq      out  FREQ_W  occurrence count of the record
//  out_queuePos  out  8       sorted rank, 0 = lowest frequency
//  out_last      out  1       final record of the table
//  num_symbols   out  8       distinct symbols held (valid from SORT onward)
//  overflow      out  1       sticky: a symbol was dropped, table full
//  busy          out  1       high in SORT or EMIT
// BEHAVIOUR
//  Reset (async, any state): state=COUNT, all slots invalid, all freqs 0,
//   num_symbols=0, overflow=0, out_valid=0, out_last=0, in_ready=1, busy=0.
//  FSM COUNT -> SORT -> EMIT -> COUNT.
//  COUNT: in_ready=1. A byte is taken when in_valid&&in_ready. Same cycle:
//   parallel match over valid slots. Hit: freq+1, saturating at 2^FREQ_W-1.
//   Miss with a free slot: lowest free slot gets {ascii=in_byte, freq=1},
//   num_symbols+1. Miss with table full: byte dropped, overflow<=1.
//   A byte taken with in_last=1 is counted first; next state SORT.
//  SORT: in_ready=0, busy=1. Odd-even transposition sort runs for exactly
//   NUM_SLOTS cycles, one compare-swap pass per cycle (even pairs first).
//   Key = {invalid, freq, ascii}, ascending: invalid slots sort last. Ties
//   on freq break by lower ascii first. Then state EMIT.
//  EMIT: out_valid=1, record k at ranks k=0..num_symbols-1, out_queuePos=k.
//   out_last=1 only when k=num_symbols-1. All outputs hold stable while
//   out_valid&&!out_ready. On each handshake, k+1 next cycle (no bubble).
//  Handshake on last record: next cycle out_valid=0, slots cleared,
//   num_symbols=0, state=COUNT. overflow stays set until reset.
//  Latency: last input byte -> first out_valid = NUM_SLOTS+1 cycles.
//  Inputs are ignored outside COUNT. in_last without in_valid has no effect.
// TESTING
//  1. Stream freqs a=45,b=13,c=12,d=16,e=9,f=5 (interleaved), last on final
//     -> records f5/0,e9/1,c12/2,b13/3,d16/4,a45/5; out_last on pos 5.
//  2. Ties: x=3,a=3,m=1 -> m1/0, a3/1, x3/2; num_symbols=3, out_last on 2.
//  3. Seven distinct symbols 'A'..'G' once each -> overflow=1, 6 records,
//     'G' absent; after drain overflow still 1, next message counts fresh.
//  4. Backpressure: out_ready low 5 cycles mid-EMIT -> record held
//     unchanged; none skipped or duplicated; in_ready=0 throughout.
//  5. Single byte 'z' with in_last -> after 7 cycles one record z1/0 with
//     out_last=1; then in_ready=1.
//  6. ctrl_reset_n low mid-SORT and mid-EMIT -> out_valid=0 immediately,
//     in_ready=1; new message afterwards has no stale counts.

Source files
------------

// File: rtl/symbol_freq_counter.sv
// Symbol frequency counter: tallies distinct bytes of a message,
// sorts them by ascending frequency and streams ranked records.
module symbol_freq_counter #(
  parameter int NUM_SLOTS = 6,
  parameter int FREQ_W    = 32,
  parameter int SYM_W     = 8
) (
  input  logic              clk,
  input  logic              ctrl_reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SYM_W-1:0]  in_byte,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_ascii,
  output logic [FREQ_W-1:0] out_freq,
  output logic [7:0]        out_queuePos,
  output logic              out_last,
  output logic [7:0]        num_symbols,
  output logic              overflow,
  output logic              busy
);

  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int KW = FREQ_W + SYM_W + 1;

  typedef enum logic [1:0] {
    S_COUNT,
    S_SORT,
    S_EMIT
  } state_e;

  state_e            state_q, state_d;
  logic              valid_q [NUM_SLOTS];
  logic              valid_d [NUM_SLOTS];
  logic [SYM_W-1:0]  ascii_q [NUM_SLOTS];
  logic [SYM_W-1:0]  ascii_d [NUM_SLOTS];
  logic [FREQ_W-1:0] freq_q  [NUM_SLOTS];
  logic [FREQ_W-1:0] freq_d  [NUM_SLOTS];
  logic [CW-1:0]     pass_q, pass_d;
  logic [7:0]        rank_q, rank_d;
  logic [7:0]        num_q, num_d;
  logic              ovf_q, ovf_d;
  logic              hit, found;
  logic [IW-1:0]     idx;

  // Invalid slots carry a set MSB so they always sink to the end.
  function automatic logic [KW-1:0] key_of(
    input logic              v,
    input logic [FREQ_W-1:0] f,
    input logic [SYM_W-1:0]  a
  );
    return {~v, f, a};
  endfunction

  assign idx          = rank_q[IW-1:0];
  assign in_ready     = (state_q == S_COUNT);
  assign busy         = (state_q == S_SORT) || (state_q == S_EMIT);
  assign out_valid    = (state_q == S_EMIT) && (num_q != 8'd0);
  assign out_ascii    = ascii_q[idx];
  assign out_freq     = freq_q[idx];
  assign out_queuePos = rank_q;
  assign out_last     = out_valid && (rank_q == num_q - 8'd1);
  assign num_symbols  = num_q;
  assign overflow     = ovf_q;

  // Next-state: counting, one sort pass per cycle, record streaming.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ascii_d = ascii_q;
    freq_d  = freq_q;
    pass_d  = pass_q;
    rank_d  = rank_q;
    num_d   = num_q;
    ovf_d   = ovf_q;
    hit     = 1'b0;
    found   = 1'b0;
    unique case (state_q)
      S_COUNT: begin
        if (in_valid) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (valid_q[i] && ascii_q[i] == in_byte) begin
              hit = 1'b1;
              if (freq_q[i] != '1)
                freq_d[i] = freq_q[i] + FREQ_W'(1);
            end
          end
          if (!hit) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (!found && !valid_q[i]) begin
                found      = 1'b1;
                valid_d[i] = 1'b1;
                ascii_d[i] = in_byte;
                freq_d[i]  = FREQ_W'(1);
              end
            end
            if (found) num_d = num_q + 8'd1;
            else       ovf_d = 1'b1;
          end
          if (in_last) begin
            state_d = S_SORT;
            pass_d  = '0;
          end
        end
      end
      S_SORT: begin
        for (int i = 0; i < NUM_SLOTS - 1; i++) begin
          if ((i % 2) == int'(pass_q[0])) begin
            if (key_of(valid_q[i], freq_q[i], ascii_q[i]) >
                key_of(valid_q[i+1], freq_q[i+1], ascii_q[i+1])) begin
              valid_d[i]   = valid_q[i+1];
              ascii_d[i]   = ascii_q[i+1];
              freq_d[i]    = freq_q[i+1];
              valid_d[i+1] = valid_q[i];
              ascii_d[i+1] = ascii_q[i];
              freq_d[i+1]  = freq_q[i];
            end
          end
        end
        pass_d = pass_q + CW'(1);
        if (pass_q == CW'(NUM_SLOTS - 1)) begin
          state_d = S_EMIT;
          rank_d  = '0;
        end
      end
      S_EMIT: begin
        if (num_q == 8'd0) begin
          state_d = S_COUNT;
        end else if (out_ready) begin
          if (out_last) begin
            state_d = S_COUNT;
            rank_d  = '0;
            num_d   = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              valid_d[i] = 1'b0;
              ascii_d[i] = '0;
              freq_d[i]  = '0;
            end
          end else begin
            rank_d = rank_q + 8'd1;
          end
        end
      end
      default: state_d = S_COUNT;
    endcase
  end

  // State and slot table registers.
  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= S_COUNT;
      pass_q  <= '0;
      rank_q  <= '0;
      num_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        valid_q[i] <= 1'b0;
        ascii_q[i] <= '0;
        freq_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      rank_q  <= rank_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        valid_q[i] <= valid_d[i];
        ascii_q[i] <= ascii_d[i];
        freq_q[i]  <= freq_d[i];
      end
    end
  end

endmodule

// File: tb/tb_symbol_freq_counter.sv
// Directed bench for symbol_freq_counter: expected
// records table plus hand-written latency/reset sequences.
module tb_symbol_freq_counter;

  logic        clk = 1'b0;
  logic        ctrl_reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_ascii;
  logic [31:0] out_freq;
  logic [7:0]  out_queuePos;
  logic        out_last;
  logic [7:0]  num_symbols;
  logic        overflow;
  logic        busy;

  symbol_freq_counter dut (
    .clk          (clk),
    .ctrl_reset_n (ctrl_reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ascii    (out_ascii),
    .out_freq     (out_freq),
    .out_queuePos (out_queuePos),
    .out_last     (out_last),
    .num_symbols  (num_symbols),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  asc;
    logic [31:0] freq;
    logic [7:0]  pos;
    logic        last;
  } rec_t;

  rec_t exp_tab[$];
  byte  msg_q[$];
  int   pass_cnt = 0;
  int   total = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic add(input byte a, input int f, input int p,
                     input bit l);
    rec_t r;
    r.asc = a; r.freq = f; r.pos = p; r.last = l;
    exp_tab.push_back(r);
  endtask

  task automatic load(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  // Drive msg_q at negedges; in_last on final byte.
  task automatic send_msg();
    for (int i = 0; i < msg_q.size(); i++) begin
      in_valid = 1'b1;
      in_byte  = msg_q[i];
      in_last  = (i == msg_q.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_rec(input int e, input string tag);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ascii"}, out_ascii, exp_tab[e].asc);
    chk({tag, "_freq"},  out_freq,  exp_tab[e].freq);
    chk({tag, "_pos"},   out_queuePos, exp_tab[e].pos);
    chk({tag, "_last"},  out_last,  exp_tab[e].last);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic recv(input int base, input int n, input int stall,
                      input int nsym, input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_first_valid"}, out_valid, 1);
    for (int k = 0; k < n; k++) begin
      out_ready = (k != stall);
      chk_rec(base + k, tag);
      chk({tag, "_nsym"}, num_symbols, nsym);
      if (k == stall) begin
        repeat (5) begin
          @(negedge clk);
          chk_rec(base + k, {tag, "_hold"});
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, out_valid, 0);
    chk({tag, "_drain_in_ready"}, in_ready, 1);
    chk({tag, "_drain_nsym"}, num_symbols, 0);
  endtask

  localparam int B1 = 0, B5 = 6, B2 = 7, B3 = 10, B3N = 16, B6 = 18;

  initial begin
    int   cnt [6];
    byte  sy  [6];
    int   t;

    add("f", 5, 0, 0); add("e", 9, 1, 0); add("c", 12, 2, 0);
    add("b", 13, 3, 0); add("d", 16, 4, 0); add("a", 45, 5, 1);
    add("z", 1, 0, 1);
    add("m", 1, 0, 0); add("a", 3, 1, 0); add("x", 3, 2, 1);
    add("A", 1, 0, 0); add("B", 1, 1, 0); add("C", 1, 2, 0);
    add("D", 1, 3, 0); add("E", 1, 4, 0); add("F", 1, 5, 1);
    add("q", 1, 0, 0); add("p", 2, 1, 1);
    add("q", 2, 0, 1);

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_nsym", num_symbols, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_last", out_last, 0);
    @(negedge clk);
    ctrl_reset_n = 1'b1;
    @(negedge clk);

    // Interleaved classic Huffman frequencies.
    cnt = '{45, 13, 12, 16, 9, 5};
    sy  = '{"a", "b", "c", "d", "e", "f"};
    msg_q.delete();
    for (int r = 0; r < 45; r++)
      for (int s = 0; s < 6; s++)
        if (cnt[s] > r) msg_q.push_back(sy[s]);
    send_msg();
    recv(B1, 6, -1, 6, "huff");

    // Single byte: exact latency to first record.
    in_valid = 1'b1; in_byte = "z"; in_last = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      if (i < 7) begin
        chk("lat_quiet_valid", out_valid, 0);
        chk("lat_busy", busy, 1);
        chk("lat_in_ready", in_ready, 0);
      end
    end
    chk("lat_valid_at_7", out_valid, 1);
    recv(B5, 1, -1, 1, "single");

    // Ties broken by ascii, with backpressure on record 1.
    load("xaxmaxa");
    send_msg();
    recv(B2, 3, 1, 3, "ties");

    // Overflow: G dropped, flag sticky, next message fresh.
    load("ABCDEFG");
    send_msg();
    chk("ovf_set", overflow, 1);
    recv(B3, 6, -1, 6, "ovf");
    chk("ovf_sticky", overflow, 1);
    load("pqp");
    send_msg();
    recv(B3N, 2, -1, 2, "fresh");
    chk("ovf_still", overflow, 1);

    // Reset during SORT.
    load("ab");
    send_msg();
    @(negedge clk);
    chk("msort_busy", busy, 1);
    ctrl_reset_n = 1'b0;
    #1;
    chk("rsort_valid", out_valid, 0);
    chk("rsort_in_ready", in_ready, 1);
    chk("rsort_busy", busy, 0);
    chk("rsort_overflow", overflow, 0);
    @(negedge clk);
    ctrl_reset_n = 1'b1;
    @(negedge clk);

    // Reset during EMIT after one record.
    load("abb");
    send_msg();
    t = 0;
    while (!out_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("memit_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("memit_pos", out_queuePos, 1);
    ctrl_reset_n = 1'b0;
    #1;
    chk("remit_valid", out_valid, 0);
    chk("remit_in_ready", in_ready, 1);
    chk("remit_nsym", num_symbols, 0);
    @(negedge clk);
    ctrl_reset_n = 1'b1;
    @(negedge clk);
    load("qq");
    send_msg();
    recv(B6, 1, -1, 1, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
